hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline hazard sequencer for the 5-stage core, sitting beside the EX/MEM forwarding unit in the ID stage.
- Handles the hazards forwarding cannot cover: load-use stalls, stalls while the multi-cycle mult/div unit is busy, and taken-branch flushes.
- Drives the PC/IF_ID write enables, the ID_EX bubble and the flush controls.
- Keeps a stall performance counter and a sticky mult/div timeout flag.

Parameters:
MD_MAX_CYCLES, 64, cycles in MD_BUSY before md_timeout is raised and the controller returns to RUN.
CNT_W, 16, width of the saturating stall_cycles counter.

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  asynchronous, active-high reset.
ID_EX_memRead  input  1  instruction in EX is a load.
ID_EX_rt  input  5  load destination register in EX.
IF_ID_rs  input  5  rs of the instruction in ID.
IF_ID_rt  input  5  rt of the instruction in ID.
IF_ID_useRt  input  1  instruction in ID reads rt as a source.
IF_ID_mdRead  input  1  instruction in ID is mfhi/mflo/mult/div.
ID_EX_mdStart  input  1  mult/div is issuing from EX this cycle.
md_done  input  1  mult/div result valid; single-cycle pulse.
EX_branchTaken  input  1  branch/jump in EX resolved taken.
PC_write  output  1  PC register enable.
IF_ID_write  output  1  IF_ID register enable.
ID_EX_bubble  output  1  zero ID_EX control bits (insert nop).
IF_ID_flush  output  1  clear IF_ID to nop.
state  output  1  0 = RUN, 1 = MD_BUSY.
md_timeout  output  1  sticky error flag.
stall_cycles  output  CNT_W  saturating count of stall cycles.

Behaviour:
Reset (rst high, asynchronous):
- state = RUN, md counter = 0, md_timeout = 0, stall_cycles = 0.
- While rst is high: PC_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, IF_ID_flush = 0.

Hazard terms (combinational):
- lu_hazard = ID_EX_memRead && ID_EX_rt != 0 && (ID_EX_rt == IF_ID_rs || (IF_ID_useRt && ID_EX_rt == IF_ID_rt)).
- md_hazard = state == MD_BUSY && IF_ID_mdRead && !md_done. md_done releases the stall in the same cycle it arrives.
- stall = (lu_hazard || md_hazard) && !EX_branchTaken.

Outputs (combinational from inputs and state):
- PC_write = !stall; IF_ID_write = !stall.
- ID_EX_bubble = stall || EX_branchTaken.
- IF_ID_flush = EX_branchTaken.

Branch priority:
- A taken branch overrides any stall, because the instruction in ID is wrong-path.
- In that cycle PC_write = 1, IF_ID_write = 1, IF_ID_flush = 1, ID_EX_bubble = 1.
- The branch flushes IF_ID and ID_EX for exactly one cycle.

State machine (registered, rising edge):
- RUN -> MD_BUSY on ID_EX_mdStart; md counter cleared to 0.
- MD_BUSY -> RUN on md_done.
- MD_BUSY -> RUN when md counter == MD_MAX_CYCLES-1 without md_done; md_timeout set to 1 and held until reset.
- Otherwise MD_BUSY increments the md counter each cycle.
- ID_EX_mdStart while in MD_BUSY: stay in MD_BUSY and restart the md counter at 0.
- md_done and ID_EX_mdStart in the same cycle: mdStart wins; next state MD_BUSY, counter 0.
- md_done while in RUN: ignored.

stall_cycles:
- Increments on every clock edge where stall = 1.
- Saturates at 2^CNT_W-1; no wrap.
- Branch-flush cycles are not counted.

Load-use stalls last exactly one cycle. The load advances to MEM and ID_EX_memRead deasserts, after which the forwarding path supplies the value.

Reset asserted mid-MD_BUSY: immediately returns to RUN; any pending mult/div result is discarded by the rest of the pipeline.

Test Plan:
- Load-use: ID_EX_memRead=1, ID_EX_rt=8, IF_ID_rs=8 for one cycle -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 that cycle; stall_cycles 0->1; next cycle (memRead=0) PC_write=1.
- Register-0 and useRt filter: ID_EX_rt=0=IF_ID_rs -> no stall. ID_EX_rt=9=IF_ID_rt with IF_ID_useRt=0 -> no stall; same with useRt=1 -> stall.
- Mult/div wait: pulse ID_EX_mdStart, state=1. Hold IF_ID_mdRead=1 -> stall for 5 cycles until md_done on cycle 6. In that cycle PC_write=1; next cycle state=0; stall_cycles=5.
- Branch priority: lu_hazard true together with EX_branchTaken=1 -> PC_write=1, IF_ID_flush=1, ID_EX_bubble=1; stall_cycles unchanged.
- Timeout: MD_MAX_CYCLES=8, mdStart with no md_done -> after 8 MD_BUSY cycles state=0 and md_timeout=1. md_timeout stays 1 after a later md_done; cleared only by rst.
- Saturation and async reset: CNT_W=3 with continuous stall -> stall_cycles sticks at 7. Assert rst between clock edges -> stall_cycles=0, state=0 immediately, PC_write=0 while rst is high.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard sequencer: load-use and mult/div stalls, taken-branch flushes,
// a saturating stall counter and a sticky mult/div timeout flag.
module hazard_stall_controller #(
  parameter int unsigned MD_MAX_CYCLES = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_useRt,
  input  logic             IF_ID_mdRead,
  input  logic             ID_EX_mdStart,
  input  logic             md_done,
  input  logic             EX_branchTaken,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             state,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MD_CW = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MD_CW-1:0] r_md_cnt;
  logic [MD_CW-1:0] w_md_cnt_nxt;
  logic             r_md_timeout;
  logic             w_md_timeout_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] w_stall_cycles_nxt;
  logic             w_lu_hazard;
  logic             w_md_hazard;
  logic             w_stall;

  // State, watchdog counter, sticky flag and performance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_md_cnt       <= '0;
      r_md_timeout   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_md_cnt       <= w_md_cnt_nxt;
      r_md_timeout   <= w_md_timeout_nxt;
      r_stall_cycles <= w_stall_cycles_nxt;
    end
  end

  // Hazard detection, pipeline controls and next-state logic.
  always_comb begin
    w_state_nxt        = r_state;
    w_md_cnt_nxt       = r_md_cnt;
    w_md_timeout_nxt   = r_md_timeout;
    w_stall_cycles_nxt = r_stall_cycles;

    w_lu_hazard = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                  ((ID_EX_rt == IF_ID_rs) || (IF_ID_useRt && (ID_EX_rt == IF_ID_rt)));
    w_md_hazard = (r_state == ST_MD_BUSY) && IF_ID_mdRead && !md_done;
    // The instruction in ID is wrong-path under a taken branch, so never stall it.
    w_stall     = (w_lu_hazard || w_md_hazard) && !EX_branchTaken;

    if (rst) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b0;
    end else begin
      PC_write     = !w_stall;
      IF_ID_write  = !w_stall;
      ID_EX_bubble = w_stall || EX_branchTaken;
      IF_ID_flush  = EX_branchTaken;
    end

    if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      w_stall_cycles_nxt = r_stall_cycles + CNT_W'(1);
    end

    case (r_state)
      ST_RUN: begin
        if (ID_EX_mdStart) begin
          w_state_nxt  = ST_MD_BUSY;
          w_md_cnt_nxt = '0;
        end
      end
      ST_MD_BUSY: begin
        // A new issue takes priority over completion of the previous op.
        if (ID_EX_mdStart) begin
          w_md_cnt_nxt = '0;
        end else if (md_done) begin
          w_state_nxt = ST_RUN;
        end else if (r_md_cnt == MD_CW'(MD_MAX_CYCLES - 1)) begin
          w_state_nxt      = ST_RUN;
          w_md_timeout_nxt = 1'b1;
        end else begin
          w_md_cnt_nxt = r_md_cnt + MD_CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign state        = (r_state == ST_MD_BUSY);
  assign md_timeout   = r_md_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with a short watchdog and narrow counter.
module tb_hazard_stall_controller;

  localparam int unsigned MD_MAX = 8;
  localparam int unsigned CW     = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ID_EX_memRead;
  logic [4:0]    ID_EX_rt;
  logic [4:0]    IF_ID_rs;
  logic [4:0]    IF_ID_rt;
  logic          IF_ID_useRt;
  logic          IF_ID_mdRead;
  logic          ID_EX_mdStart;
  logic          md_done;
  logic          EX_branchTaken;
  logic          PC_write;
  logic          IF_ID_write;
  logic          ID_EX_bubble;
  logic          IF_ID_flush;
  logic          state;
  logic          md_timeout;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_controller #(
    .MD_MAX_CYCLES(MD_MAX),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_EX_memRead (ID_EX_memRead),
    .ID_EX_rt      (ID_EX_rt),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .IF_ID_useRt   (IF_ID_useRt),
    .IF_ID_mdRead  (IF_ID_mdRead),
    .ID_EX_mdStart (ID_EX_mdStart),
    .md_done       (md_done),
    .EX_branchTaken(EX_branchTaken),
    .PC_write      (PC_write),
    .IF_ID_write   (IF_ID_write),
    .ID_EX_bubble  (ID_EX_bubble),
    .IF_ID_flush   (IF_ID_flush),
    .state         (state),
    .md_timeout    (md_timeout),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ID_EX_memRead = 1'b0; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
    IF_ID_useRt = 1'b0; IF_ID_mdRead = 1'b0; ID_EX_mdStart = 1'b0;
    md_done = 1'b0; EX_branchTaken = 1'b0;

    // Reset state
    #3;
    chk("rst_pc_write", 32'(PC_write), 32'd0);
    chk("rst_ifid_write", 32'(IF_ID_write), 32'd0);
    chk("rst_bubble", 32'(ID_EX_bubble), 32'd1);
    chk("rst_flush", 32'(IF_ID_flush), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_timeout", 32'(md_timeout), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_pc_write", 32'(PC_write), 32'd1);
    chk("idle_bubble", 32'(ID_EX_bubble), 32'd0);

    // Load-use on rs
    ID_EX_memRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
    #1;
    chk("lu_pc_write", 32'(PC_write), 32'd0);
    chk("lu_ifid_write", 32'(IF_ID_write), 32'd0);
    chk("lu_bubble", 32'(ID_EX_bubble), 32'd1);
    chk("lu_flush", 32'(IF_ID_flush), 32'd0);
    tick();
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    ID_EX_memRead = 1'b0;
    #1;
    chk("lu_release_pc", 32'(PC_write), 32'd1);
    chk("lu_release_bubble", 32'(ID_EX_bubble), 32'd0);
    tick();
    chk("lu_cnt_hold", 32'(stall_cycles), 32'd1);

    // Register-0 and useRt filtering
    ID_EX_memRead = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0;
    #1;
    chk("r0_no_stall", 32'(PC_write), 32'd1);
    ID_EX_rt = 5'd9; IF_ID_rt = 5'd9; IF_ID_rs = 5'd1; IF_ID_useRt = 1'b0;
    #1;
    chk("rt_unused_no_stall", 32'(PC_write), 32'd1);
    IF_ID_useRt = 1'b1;
    #1;
    chk("rt_used_stall", 32'(PC_write), 32'd0);
    tick();
    chk("rt_stall_cnt", 32'(stall_cycles), 32'd2);
    ID_EX_memRead = 1'b0; IF_ID_useRt = 1'b0;
    pulse_reset();
    chk("reset_clears_cnt", 32'(stall_cycles), 32'd0);

    // mult/div wait: mdRead outside MD_BUSY does not stall
    IF_ID_mdRead = 1'b1;
    #1;
    chk("mdread_run_no_stall", 32'(PC_write), 32'd1);
    IF_ID_mdRead = 1'b0;
    tick();
    ID_EX_mdStart = 1'b1;
    tick();
    ID_EX_mdStart = 1'b0;
    chk("md_state_busy", 32'(state), 32'd1);
    IF_ID_mdRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("md_stall_%0d", i), 32'(PC_write), 32'd0);
      tick();
    end
    md_done = 1'b1;
    #1;
    chk("md_done_pc_write", 32'(PC_write), 32'd1);
    chk("md_done_bubble", 32'(ID_EX_bubble), 32'd0);
    tick();
    md_done = 1'b0; IF_ID_mdRead = 1'b0;
    chk("md_state_run", 32'(state), 32'd0);
    chk("md_stall_cnt", 32'(stall_cycles), 32'd5);
    chk("md_no_timeout", 32'(md_timeout), 32'd0);

    // Branch overrides load-use
    ID_EX_memRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; EX_branchTaken = 1'b1;
    #1;
    chk("br_pc_write", 32'(PC_write), 32'd1);
    chk("br_ifid_write", 32'(IF_ID_write), 32'd1);
    chk("br_flush", 32'(IF_ID_flush), 32'd1);
    chk("br_bubble", 32'(ID_EX_bubble), 32'd1);
    tick();
    chk("br_cnt_unchanged", 32'(stall_cycles), 32'd5);
    ID_EX_memRead = 1'b0; EX_branchTaken = 1'b0;
    #1;
    chk("br_flush_one_cycle", 32'(IF_ID_flush), 32'd0);

    // Watchdog timeout after MD_MAX busy cycles
    ID_EX_mdStart = 1'b1;
    tick();
    ID_EX_mdStart = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_still_busy", 32'(state), 32'd1);
    chk("to_not_yet", 32'(md_timeout), 32'd0);
    tick();
    chk("to_state_run", 32'(state), 32'd0);
    chk("to_flag_set", 32'(md_timeout), 32'd1);
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("to_sticky", 32'(md_timeout), 32'd1);
    chk("done_in_run_ignored", 32'(state), 32'd0);

    // mdStart beats md_done in the same cycle
    ID_EX_mdStart = 1'b1;
    tick();
    md_done = 1'b1;
    tick();
    ID_EX_mdStart = 1'b0;
    chk("start_wins", 32'(state), 32'd1);
    tick();
    md_done = 1'b0;
    chk("done_to_run", 32'(state), 32'd0);

    // Saturation with continuous load-use stall
    ID_EX_memRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
    for (int i = 0; i < 4; i++) tick();
    chk("sat_cnt", 32'(stall_cycles), 32'd7);
    ID_EX_mdStart = 1'b1;
    tick();
    ID_EX_mdStart = 1'b0;
    chk("sat_hold", 32'(stall_cycles), 32'd7);
    chk("pre_rst_busy", 32'(state), 32'd1);

    // Asynchronous reset mid-cycle while MD_BUSY
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(stall_cycles), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_timeout", 32'(md_timeout), 32'd0);
    chk("arst_pc_write", 32'(PC_write), 32'd0);
    chk("arst_bubble", 32'(ID_EX_bubble), 32'd1);
    ID_EX_memRead = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_pc_write", 32'(PC_write), 32'd1);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
